// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS32 main control FSM with retire counter and halt on illegal opcode
module mc_ctrl #(
    parameter int OPCODE_LEN = 6,
    parameter int ALUOP_LEN  = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_LEN-1:0] OpCode,
    input  logic                  Zero,
    input  logic                  MemRdy,
    output logic                  PCWr,
    output logic                  PCWrCond,
    output logic                  IorD,
    output logic                  MemRd,
    output logic                  MemWr,
    output logic                  IRWr,
    output logic                  MemtoReg,
    output logic                  RegDst,
    output logic                  RegWr,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            PCSrc,
    output logic [ALUOP_LEN-1:0]  ALUOp,
    output logic [3:0]            State,
    output logic                  Halted,
    output logic [CNT_W-1:0]      InstCnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [OPCODE_LEN-1:0] OP_RTYPE = OPCODE_LEN'(6'b000000);
    localparam logic [OPCODE_LEN-1:0] OP_LW    = OPCODE_LEN'(6'b100011);
    localparam logic [OPCODE_LEN-1:0] OP_SW    = OPCODE_LEN'(6'b101011);
    localparam logic [OPCODE_LEN-1:0] OP_BEQ   = OPCODE_LEN'(6'b000100);
    localparam logic [OPCODE_LEN-1:0] OP_J     = OPCODE_LEN'(6'b000010);
    localparam logic [OPCODE_LEN-1:0] OP_ADDI  = OPCODE_LEN'(6'b001000);

    localparam logic [ALUOP_LEN-1:0] ALUOP_ADD   = ALUOP_LEN'(0);
    localparam logic [ALUOP_LEN-1:0] ALUOP_SUB   = ALUOP_LEN'(1);
    localparam logic [ALUOP_LEN-1:0] ALUOP_FUNCT = ALUOP_LEN'(2);

    state_t            state_q, state_d;
    logic              halted_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              retire;

    // Zero is qualified in the datapath via PCWrCond; the sequencing never depends on it.
    logic unused_zero;
    assign unused_zero = Zero;

    // State register, sticky halt flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT) begin
                halted_q <= 1'b1;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state sequencing; retire marks the edge that leaves an instruction's last state.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (MemRdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (MemRdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (MemRdy) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore decode of datapath controls; reset blanks everything without waiting for a clock.
    always_comb begin
        PCWr     = 1'b0;
        PCWrCond = 1'b0;
        IorD     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        IRWr     = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWr    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        ALUOp    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                IRWr    = MemRdy;
                PCWr    = MemRdy;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
            end
            S_MEMWB: begin
                RegWr    = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWr = 1'b1;
                IorD  = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWr  = 1'b1;
                RegDst = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCWrCond = 1'b1;
                PCSrc    = 2'b01;
            end
            S_JUMP: begin
                PCWr  = 1'b1;
                PCSrc = 2'b10;
            end
            S_ADDIWB: RegWr = 1'b1;
            default: ;
        endcase
        if (!rst) begin
            PCWr     = 1'b0;
            PCWrCond = 1'b0;
            IorD     = 1'b0;
            MemRd    = 1'b0;
            MemWr    = 1'b0;
            IRWr     = 1'b0;
            MemtoReg = 1'b0;
            RegDst   = 1'b0;
            RegWr    = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            PCSrc    = 2'b00;
            ALUOp    = ALUOP_ADD;
        end
    end

    assign State   = state_q;
    assign Halted  = halted_q;
    assign InstCnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl: vector table, corner sequences, random model run
module tb_mc_ctrl;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       OpCode;
    logic             Zero;
    logic             MemRdy;
    logic             PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr;
    logic             MemtoReg, RegDst, RegWr, ALUSrcA;
    logic [1:0]       ALUSrcB, PCSrc, ALUOp;
    logic [3:0]       State;
    logic             Halted;
    logic [CNT_W-1:0] InstCnt;

    int tests = 0;
    int fails = 0;

    mc_ctrl #(.OPCODE_LEN(6), .ALUOP_LEN(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Zero(Zero), .MemRdy(MemRdy),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
        .IRWr(IRWr), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWr(RegWr),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .State(State), .Halted(Halted), .InstCnt(InstCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] bus;
        int          cnt;
    } vec_t;

    vec_t vt [24];

    function automatic logic [15:0] bus_now();
        return {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, RegDst, RegWr,
                ALUSrcA, ALUSrcB, PCSrc, ALUOp};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs (called at posedge+1), check at negedge, return at next posedge+1.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [3:0] est, input logic [15:0] ebus, input int ecnt);
        OpCode = op;
        MemRdy = rdy;
        @(negedge clk);
        chk({tag, ".state"}, 32'(State), 32'(est));
        chk({tag, ".bus"}, 32'(bus_now()), 32'(ebus));
        chk({tag, ".cnt"}, 32'(InstCnt), 32'(ecnt % (1 << CNT_W)));
        @(posedge clk);
        #1;
    endtask

    // Reference: each instruction is its sequence of architectural phases.
    function automatic int path_len(input logic [5:0] op);
        case (op)
            OP_R:    return 4;
            OP_LW:   return 5;
            OP_SW:   return 4;
            OP_BEQ:  return 3;
            OP_J:    return 3;
            OP_ADDI: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [3:0] path_state(input logic [5:0] op, input int k);
        logic [3:0] p [5];
        case (op)
            OP_R:    p = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
            OP_LW:   p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            OP_SW:   p = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
            OP_BEQ:  p = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
            OP_J:    p = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
            OP_ADDI: p = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
            default: p = '{4'd12, 4'd12, 4'd12, 4'd12, 4'd12};
        endcase
        return p[k];
    endfunction

    initial begin
        logic [5:0] ops [6];
        logic [5:0] cur_op;
        logic [3:0] est;
        logic       r;
        int         k;
        int         mcnt;
        logic [5:0] exp_str;

        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

        vt[0]  = '{OP_R,    1'b1, 4'd0,  16'h9410, 0};
        vt[1]  = '{OP_R,    1'b1, 4'd1,  16'h0030, 0};
        vt[2]  = '{OP_R,    1'b1, 4'd6,  16'h0042, 0};
        vt[3]  = '{OP_R,    1'b1, 4'd7,  16'h0180, 0};
        vt[4]  = '{OP_LW,   1'b1, 4'd0,  16'h9410, 1};
        vt[5]  = '{OP_LW,   1'b1, 4'd1,  16'h0030, 1};
        vt[6]  = '{OP_LW,   1'b1, 4'd2,  16'h0060, 1};
        vt[7]  = '{OP_LW,   1'b1, 4'd3,  16'h3000, 1};
        vt[8]  = '{OP_LW,   1'b1, 4'd4,  16'h0280, 1};
        vt[9]  = '{OP_SW,   1'b1, 4'd0,  16'h9410, 2};
        vt[10] = '{OP_SW,   1'b1, 4'd1,  16'h0030, 2};
        vt[11] = '{OP_SW,   1'b1, 4'd2,  16'h0060, 2};
        vt[12] = '{OP_SW,   1'b1, 4'd5,  16'h2800, 2};
        vt[13] = '{OP_BEQ,  1'b1, 4'd0,  16'h9410, 3};
        vt[14] = '{OP_BEQ,  1'b1, 4'd1,  16'h0030, 3};
        vt[15] = '{OP_BEQ,  1'b1, 4'd8,  16'h4045, 3};
        vt[16] = '{OP_J,    1'b1, 4'd0,  16'h9410, 4};
        vt[17] = '{OP_J,    1'b1, 4'd1,  16'h0030, 4};
        vt[18] = '{OP_J,    1'b1, 4'd9,  16'h8008, 4};
        vt[19] = '{OP_ADDI, 1'b1, 4'd0,  16'h9410, 5};
        vt[20] = '{OP_ADDI, 1'b1, 4'd1,  16'h0030, 5};
        vt[21] = '{OP_ADDI, 1'b1, 4'd10, 16'h0060, 5};
        vt[22] = '{OP_ADDI, 1'b1, 4'd11, 16'h0080, 5};
        vt[23] = '{OP_R,    1'b0, 4'd0,  16'h1010, 6};

        // Reset state: FETCH, but every control held low while rst is asserted.
        rst    = 1'b0;
        OpCode = OP_R;
        Zero   = 1'b0;
        MemRdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.state", 32'(State), 32'd0);
        chk("reset.bus", 32'(bus_now()), 32'd0);
        chk("reset.halted", 32'(Halted), 32'd0);
        chk("reset.cnt", 32'(InstCnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // One of each instruction with MemRdy high, then a stalled fetch.
        for (int i = 0; i < 24; i++) begin
            cyc($sformatf("vec%0d", i), vt[i].op, vt[i].rdy, vt[i].st, vt[i].bus, vt[i].cnt);
        end

        // lw with three wait cycles in MEMRD: eight cycles total.
        cyc("lws.f",  OP_LW, 1'b1, 4'd0, 16'h9410, 6);
        cyc("lws.d",  OP_LW, 1'b1, 4'd1, 16'h0030, 6);
        cyc("lws.a",  OP_LW, 1'b1, 4'd2, 16'h0060, 6);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("lws.w%0d", i), OP_LW, 1'b0, 4'd3, 16'h3000, 6);
        end
        cyc("lws.r",  OP_LW, 1'b1, 4'd3, 16'h3000, 6);
        cyc("lws.wb", OP_LW, 1'b1, 4'd4, 16'h0280, 6);

        // Illegal opcode: DECODE -> HALT and stays quiet.
        cyc("ill.f", OP_ILL, 1'b1, 4'd0, 16'h9410, 7);
        cyc("ill.d", OP_ILL, 1'b1, 4'd1, 16'h0030, 7);
        for (int i = 0; i < 20; i++) begin
            OpCode = 6'($urandom);
            MemRdy = 1'($urandom);
            @(negedge clk);
            chk($sformatf("halt%0d.state", i), 32'(State), 32'd12);
            chk($sformatf("halt%0d.bus", i), 32'(bus_now()), 32'd0);
            chk($sformatf("halt%0d.halted", i), 32'(Halted), 32'd1);
            chk($sformatf("halt%0d.cnt", i), 32'(InstCnt), 32'd7);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("halt.rst.state", 32'(State), 32'd0);
        chk("halt.rst.halted", 32'(Halted), 32'd0);
        chk("halt.rst.cnt", 32'(InstCnt), 32'd0);
        chk("halt.rst.bus", 32'(bus_now()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random instruction stream with random memory stalls against the phase model.
        k      = 0;
        mcnt   = 0;
        cur_op = ops[$urandom_range(0, 5)];
        for (int i = 0; i < 700; i++) begin
            r      = ($urandom_range(0, 3) != 0);
            OpCode = cur_op;
            MemRdy = r;
            @(negedge clk);
            est     = path_state(cur_op, k);
            exp_str = {est == 4'd0 || est == 4'd3,
                       est == 4'd5,
                       est == 4'd4 || est == 4'd7 || est == 4'd11,
                       est == 4'd0 && r,
                       (est == 4'd0 && r) || est == 4'd9,
                       est == 4'd8};
            chk($sformatf("rnd%0d.state", i), 32'(State), 32'(est));
            chk($sformatf("rnd%0d.strobes", i),
                32'({MemRd, MemWr, RegWr, IRWr, PCWr, PCWrCond}), 32'(exp_str));
            chk($sformatf("rnd%0d.cnt", i), 32'(InstCnt), 32'(mcnt));
            if (!((est == 4'd0 || est == 4'd3 || est == 4'd5) && !r)) begin
                if (k == path_len(cur_op) - 1) begin
                    mcnt   = (mcnt + 1) % (1 << CNT_W);
                    k      = 0;
                    cur_op = ops[$urandom_range(0, 5)];
                end else begin
                    k++;
                end
            end
            @(posedge clk);
            #1;
        end

        // Reset while waiting in MEMRD: controls drop at once and nothing retires.
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("abort.f", OP_LW, 1'b1, 4'd0, 16'h9410, 0);
        cyc("abort.d", OP_LW, 1'b1, 4'd1, 16'h0030, 0);
        cyc("abort.a", OP_LW, 1'b1, 4'd2, 16'h0060, 0);
        cyc("abort.w", OP_LW, 1'b0, 4'd3, 16'h3000, 0);
        rst = 1'b0;
        #1;
        chk("abort.bus", 32'(bus_now()), 32'd0);
        chk("abort.state", 32'(State), 32'd0);
        MemRdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort.cnt", 32'(InstCnt), 32'd0);
        chk("abort.bus2", 32'(bus_now()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
